// File: rtl/pu_riscv_dmem_arbiter_if.sv
// Signal bundle between the LSU, the debug port, the data-memory bus and the arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding requesters and memory.
interface pu_riscv_dmem_arbiter_if #(
  parameter int XLEN = 64
);
  logic            lsu_req;
  logic [XLEN-1:0] lsu_adr;
  logic            lsu_we;
  logic [2:0]      lsu_size;
  logic [XLEN-1:0] lsu_d;
  logic            lsu_ack;
  logic [XLEN-1:0] lsu_q;
  logic            lsu_misaligned;
  logic            lsu_err;
  logic            stall;

  logic            dbg_req;
  logic [XLEN-1:0] dbg_adr;
  logic            dbg_we;
  logic [XLEN-1:0] dbg_d;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_q;
  logic            dbg_err;

  logic            mem_req;
  logic [XLEN-1:0] mem_adr;
  logic            mem_we;
  logic [2:0]      mem_size;
  logic [XLEN-1:0] mem_d;
  logic            mem_ack;
  logic            mem_err;
  logic [XLEN-1:0] mem_q;

  modport master (
    input  lsu_req, lsu_adr, lsu_we, lsu_size, lsu_d,
    output lsu_ack, lsu_q, lsu_misaligned, lsu_err, stall,
    input  dbg_req, dbg_adr, dbg_we, dbg_d,
    output dbg_ack, dbg_q, dbg_err,
    output mem_req, mem_adr, mem_we, mem_size, mem_d,
    input  mem_ack, mem_err, mem_q
  );

  modport slave (
    output lsu_req, lsu_adr, lsu_we, lsu_size, lsu_d,
    input  lsu_ack, lsu_q, lsu_misaligned, lsu_err, stall,
    output dbg_req, dbg_adr, dbg_we, dbg_d,
    input  dbg_ack, dbg_q, dbg_err,
    input  mem_req, mem_adr, mem_we, mem_size, mem_d,
    output mem_ack, mem_err, mem_q
  );
endinterface

// File: rtl/pu_riscv_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory bus between the LSU and the debug port,
// with LSU alignment checking and a bus wait timeout.
module pu_riscv_dmem_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input logic                     clk,
  input logic                     rstn,
  pu_riscv_dmem_arbiter_if.master bus
);
  localparam int               CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [2:0]       DBG_SIZE = (XLEN == 64) ? 3'b011 : 3'b010;

  typedef enum logic [1:0] {IDLE, LSU, DBG} state_t;
  typedef enum logic {GNT_LSU, GNT_DBG} grant_t;

  state_t           state;
  state_t           state_nxt;
  grant_t           last_grant;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       align_mask;
  logic             lsu_elig;
  logic             dbg_elig;
  logic             lsu_misalign;
  logic             lsu_bad;
  logic             grant_lsu;
  logic             grant_dbg;
  logic             term;
  logic             timed_out;
  logic [XLEN-1:0]  rsp_q;
  logic             rsp_err;

  // A requester whose ack is showing this cycle is finishing, not asking again.
  assign lsu_elig = bus.lsu_req & ~bus.lsu_ack;
  assign dbg_elig = bus.dbg_req & ~bus.dbg_ack;

  always_comb begin
    align_mask = 3'b000;
    case (bus.lsu_size[1:0])
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      2'b11:   align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  assign lsu_misalign = bus.lsu_size[2]
                      | ((bus.lsu_size == 3'b011) && (XLEN == 32))
                      | (|(bus.lsu_adr[2:0] & align_mask));

  // A real response wins over a timeout landing on the same cycle.
  assign term      = bus.mem_ack | bus.mem_err | (cnt == CNT_MAX);
  assign timed_out = (cnt == CNT_MAX) & ~bus.mem_ack & ~bus.mem_err;
  assign rsp_q     = timed_out ? '0 : bus.mem_q;
  assign rsp_err   = bus.mem_err | timed_out;

  assign bus.mem_req = (state != IDLE);
  assign bus.stall   = bus.lsu_req & ~bus.lsu_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_lsu = 1'b0;
    grant_dbg = 1'b0;
    lsu_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_elig && (!dbg_elig || last_grant == GNT_DBG)) begin
          if (lsu_misalign) begin
            lsu_bad = 1'b1;
          end else begin
            grant_lsu = 1'b1;
            state_nxt = LSU;
          end
        end else if (dbg_elig) begin
          grant_dbg = 1'b1;
          state_nxt = DBG;
        end
      end
      LSU, DBG: begin
        if (term) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response strobes default low so every ack is a single-cycle pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant         <= GNT_DBG;
      cnt                <= '0;
      bus.mem_adr        <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_size       <= 3'b000;
      bus.mem_d          <= '0;
      bus.lsu_ack        <= 1'b0;
      bus.lsu_q          <= '0;
      bus.lsu_misaligned <= 1'b0;
      bus.lsu_err        <= 1'b0;
      bus.dbg_ack        <= 1'b0;
      bus.dbg_q          <= '0;
      bus.dbg_err        <= 1'b0;
    end else begin
      bus.lsu_ack        <= 1'b0;
      bus.lsu_q          <= '0;
      bus.lsu_misaligned <= 1'b0;
      bus.lsu_err        <= 1'b0;
      bus.dbg_ack        <= 1'b0;
      bus.dbg_q          <= '0;
      bus.dbg_err        <= 1'b0;

      if (grant_lsu) begin
        bus.mem_adr  <= bus.lsu_adr;
        bus.mem_we   <= bus.lsu_we;
        bus.mem_size <= bus.lsu_size;
        bus.mem_d    <= bus.lsu_d;
        last_grant   <= GNT_LSU;
        cnt          <= '0;
      end else if (grant_dbg) begin
        bus.mem_adr  <= bus.dbg_adr;
        bus.mem_we   <= bus.dbg_we;
        bus.mem_size <= DBG_SIZE;
        bus.mem_d    <= bus.dbg_d;
        last_grant   <= GNT_DBG;
        cnt          <= '0;
      end

      if (lsu_bad) begin
        bus.lsu_ack        <= 1'b1;
        bus.lsu_misaligned <= 1'b1;
      end

      if (state == LSU || state == DBG) begin
        if (term) begin
          if (state == LSU) begin
            bus.lsu_ack <= 1'b1;
            bus.lsu_q   <= rsp_q;
            bus.lsu_err <= rsp_err;
          end else begin
            bus.dbg_ack <= 1'b1;
            bus.dbg_q   <= rsp_q;
            bus.dbg_err <= rsp_err;
          end
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pu_riscv_dmem_arbiter.sv
// Randomised scoreboard bench for pu_riscv_dmem_arbiter: requesters push expected responses,
// an address-driven memory model answers the bus, and a negedge monitor pops and compares.
module tb_pu_riscv_dmem_arbiter;
  localparam int XLEN = 64;
  localparam int TMO  = 15;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pu_riscv_dmem_arbiter_if #(.XLEN(XLEN)) bus ();

  pu_riscv_dmem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] q;
    logic        err;
    logic        mis;
    logic        has_bus;
    logic [63:0] adr;
    logic        we;
    logic [2:0]  size;
    logic [63:0] d;
    int          len;
    int          req_cyc;
    logic        solo;
  } exp_t;

  typedef struct {
    logic [63:0] adr;
    logic        we;
    logic [2:0]  size;
    logic [63:0] d;
    int          len;
    int          start_cyc;
    int          end_cyc;
    logic        stable;
  } bus_t;

  exp_t lsu_exp[$];
  exp_t dbg_exp[$];
  bus_t bus_q[$];
  int   ack_log[$];

  // Memory behaviour is a pure function of the address: D = error only, E = never answers, F = ack+error.
  function automatic logic [63:0] rdata(logic [63:0] adr);
    if (adr == 64'h1000) return 64'hDEAD_BEEF;
    return {~adr[31:0], adr[31:0] ^ 32'h5A5A_C3C3};
  endfunction

  function automatic int latency(logic [63:0] adr);
    if (adr == 64'h1000) return 3;
    if (adr[15:12] == 4'hE) return -1;
    return int'(adr[6:4]);
  endfunction

  function automatic exp_t buildExpect(bit dbg, logic [63:0] adr, logic we, logic [2:0] size,
                                       logic [63:0] d);
    exp_t e;
    int   lat;
    lat   = latency(adr);
    e.mis = 1'b0;
    if (!dbg) begin
      if (size > 3'd3) e.mis = 1'b1;
      else if ((adr % (64'd1 << size)) != 64'd0) e.mis = 1'b1;
    end
    e.has_bus = !e.mis;
    e.adr     = adr;
    e.we      = we;
    e.size    = dbg ? 3'b011 : size;
    e.d       = d;
    if (e.mis) begin
      e.q   = 64'd0;
      e.err = 1'b0;
      e.len = 0;
    end else begin
      e.q   = (lat < 0) ? 64'd0 : rdata(adr);
      e.err = (adr[15:12] == 4'hD) || (adr[15:12] == 4'hE) || (adr[15:12] == 4'hF);
      e.len = (lat < 0) ? TMO + 1 : lat + 1;
    end
    e.req_cyc = 0;
    e.solo    = 1'b0;
    return e;
  endfunction

  function automatic logic [63:0] randAdr();
    int         r;
    logic [3:0] nib;
    r = $urandom_range(0, 15);
    if (r < 9)       nib = 4'($urandom_range(1, 3));
    else if (r < 11) nib = 4'hD;
    else if (r < 13) nib = 4'hF;
    else if (r == 13) nib = 4'hE;
    else             nib = 4'h2;
    return {48'h0, nib, 12'($urandom)};
  endfunction

  function automatic logic [63:0] alignedAdr();
    return {48'h0, 4'h1, 9'($urandom), 3'b000};
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(bit dbg, logic [63:0] adr, logic we, logic [2:0] size,
                               logic [63:0] d, bit solo);
    exp_t e;
    e         = buildExpect(dbg, adr, we, size, d);
    e.req_cyc = cyc;
    e.solo    = solo;
    if (dbg) begin
      dbg_exp.push_back(e);
      bus.dbg_adr = adr;
      bus.dbg_we  = we;
      bus.dbg_d   = d;
      bus.dbg_req = 1'b1;
    end else begin
      lsu_exp.push_back(e);
      bus.lsu_adr  = adr;
      bus.lsu_we   = we;
      bus.lsu_size = size;
      bus.lsu_d    = d;
      bus.lsu_req  = 1'b1;
    end
  endtask

  task automatic waitAck(bit dbg);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(dbg ? bus.dbg_ack : bus.lsu_ack) && n < 64);
    if (!(dbg ? bus.dbg_ack : bus.lsu_ack)) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_ack_wait actual=no ack expected=ack within 64 cycles",
               dbg ? "dbg" : "lsu");
    end
  endtask

  task automatic doTxn(bit dbg, logic [63:0] adr, logic we, logic [2:0] size,
                       logic [63:0] d, bit solo);
    applyStimulus(dbg, adr, we, size, d, solo);
    waitAck(dbg);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic handleAck(bit dbg);
    exp_t  e;
    bus_t  b;
    string p;
    p = dbg ? "dbg" : "lsu";
    if ((dbg ? dbg_exp.size() : lsu_exp.size()) == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_ack_unexpected actual=ack expected=no ack (cycle %0d)", p, cyc);
      return;
    end
    e = dbg ? dbg_exp.pop_front() : lsu_exp.pop_front();
    checkOutput({p, "_q"},   dbg ? bus.dbg_q : bus.lsu_q, e.q);
    checkOutput({p, "_err"}, dbg ? bus.dbg_err : bus.lsu_err, e.err);
    if (!dbg) checkOutput("lsu_misaligned", bus.lsu_misaligned, e.mis);
    if (e.has_bus) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_bus_txn actual=none expected=one bus transaction", p);
      end else begin
        b = bus_q.pop_front();
        checkOutput({p, "_mem_adr"},  b.adr, e.adr);
        checkOutput({p, "_mem_we"},   b.we, e.we);
        checkOutput({p, "_mem_size"}, b.size, e.size);
        checkOutput({p, "_mem_d"},    b.d, e.d);
        checkOutput({p, "_req_len"},  b.len, e.len);
        checkOutput({p, "_stable"},   b.stable, 1'b1);
        checkOutput({p, "_ack_lat"},  cyc, b.end_cyc);
        if (e.solo) checkOutput({p, "_grant_lat"}, b.start_cyc, e.req_cyc + 1);
      end
      ack_log.push_back(dbg ? 1 : 0);
    end else begin
      checkOutput("mis_no_bus", bus_q.size(), 0);
      if (e.solo) checkOutput("mis_ack_lat", cyc, e.req_cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      checkOutput("stall", bus.stall, bus.lsu_req & ~bus.lsu_ack);
      if (bus.lsu_ack) handleAck(1'b0);
      if (bus.dbg_ack) handleAck(1'b1);
    end
  end

  // Memory model: answers after an address-derived delay and logs each mem_req burst.
  initial begin
    bus_t cur;
    bit   in_burst;
    int   k;
    int   lat;
    in_burst    = 1'b0;
    k           = 0;
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;
    bus.mem_q   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        in_burst    = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
      end else if (bus.mem_req) begin
        if (!in_burst) begin
          in_burst      = 1'b1;
          k             = 0;
          cur.adr       = bus.mem_adr;
          cur.we        = bus.mem_we;
          cur.size      = bus.mem_size;
          cur.d         = bus.mem_d;
          cur.stable    = 1'b1;
          cur.start_cyc = cyc;
        end else if (bus.mem_adr !== cur.adr || bus.mem_we !== cur.we ||
                     bus.mem_size !== cur.size || bus.mem_d !== cur.d) begin
          cur.stable = 1'b0;
        end
        lat = latency(cur.adr);
        if (lat >= 0 && k == lat) begin
          bus.mem_ack = (cur.adr[15:12] != 4'hD);
          bus.mem_err = (cur.adr[15:12] == 4'hD) || (cur.adr[15:12] == 4'hF);
          bus.mem_q   = rdata(cur.adr);
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_err = 1'b0;
          bus.mem_q   = {$urandom, $urandom};
        end
        k++;
      end else begin
        if (in_burst) begin
          cur.len     = k;
          cur.end_cyc = cyc;
          bus_q.push_back(cur);
          in_burst = 1'b0;
        end
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
        bus.mem_q   = {$urandom, $urandom};
      end
    end
  end

  initial begin
    rstn         = 1'b0;
    bus.lsu_req  = 1'b0;
    bus.lsu_adr  = '0;
    bus.lsu_we   = 1'b0;
    bus.lsu_size = 3'b000;
    bus.lsu_d    = '0;
    bus.dbg_req  = 1'b0;
    bus.dbg_adr  = '0;
    bus.dbg_we   = 1'b0;
    bus.dbg_d    = '0;
    idle(2);

    checkOutput("rst_mem_req",  bus.mem_req, 1'b0);
    checkOutput("rst_mem_adr",  bus.mem_adr, 64'd0);
    checkOutput("rst_mem_we",   bus.mem_we, 1'b0);
    checkOutput("rst_mem_size", bus.mem_size, 3'd0);
    checkOutput("rst_mem_d",    bus.mem_d, 64'd0);
    checkOutput("rst_lsu_ack",  bus.lsu_ack, 1'b0);
    checkOutput("rst_lsu_q",    bus.lsu_q, 64'd0);
    checkOutput("rst_lsu_err",  bus.lsu_err, 1'b0);
    checkOutput("rst_lsu_mis",  bus.lsu_misaligned, 1'b0);
    checkOutput("rst_dbg_ack",  bus.dbg_ack, 1'b0);
    checkOutput("rst_dbg_q",    bus.dbg_q, 64'd0);
    checkOutput("rst_dbg_err",  bus.dbg_err, 1'b0);
    checkOutput("rst_stall",    bus.stall, 1'b0);

    rstn = 1'b1;
    idle(1);

    doTxn(1'b0, 64'h1000, 1'b0, 3'b010, 64'd0, 1'b1);
    bus.lsu_req = 1'b0;
    idle(3);
    doTxn(1'b0, 64'h1001, 1'b0, 3'b001, 64'h11, 1'b1);
    bus.lsu_req = 1'b0;
    idle(2);
    doTxn(1'b0, 64'h1000, 1'b1, 3'b100, 64'h22, 1'b1);
    bus.lsu_req = 1'b0;
    idle(2);
    doTxn(1'b1, 64'hE040, 1'b0, 3'b000, 64'h33, 1'b1);
    bus.dbg_req = 1'b0;
    idle(2);
    doTxn(1'b1, 64'hF008, 1'b1, 3'b000, 64'h0123_4567_89AB_CDEF, 1'b1);
    bus.dbg_req = 1'b0;
    idle(1);
    doTxn(1'b0, 64'hD010, 1'b0, 3'b011, 64'h44, 1'b1);
    bus.lsu_req = 1'b0;
    idle(2);

    // Both requesters saturate the bus from reset release; grants must alternate LSU first.
    rstn = 1'b0;
    ack_log.delete();
    applyStimulus(1'b0, alignedAdr(), 1'b0, 3'b011, {$urandom, $urandom}, 1'b0);
    applyStimulus(1'b1, alignedAdr(), 1'b1, 3'b000, {$urandom, $urandom}, 1'b0);
    #2 rstn = 1'b1;
    fork
      begin
        waitAck(1'b0);
        repeat (5) doTxn(1'b0, alignedAdr(), 1'(($urandom)), 3'b011, {$urandom, $urandom}, 1'b0);
        bus.lsu_req = 1'b0;
      end
      begin
        waitAck(1'b1);
        repeat (5) doTxn(1'b1, alignedAdr(), 1'(($urandom)), 3'b000, {$urandom, $urandom}, 1'b0);
        bus.dbg_req = 1'b0;
      end
    join
    idle(3);
    checkOutput("grant_count", ack_log.size(), 12);
    for (int i = 0; i < ack_log.size(); i++) checkOutput("grant_order", ack_log[i], i % 2);

    // Reset in the middle of a bus transaction; the held request must be replayed.
    applyStimulus(1'b0, 64'h1070, 1'b0, 3'b010, 64'h55, 1'b0);
    idle(3);
    checkOutput("mem_req_before_rst", bus.mem_req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mem_req_in_rst", bus.mem_req, 1'b0);
    checkOutput("lsu_ack_in_rst", bus.lsu_ack, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b1;
    waitAck(1'b0);
    bus.lsu_req = 1'b0;
    idle(2);

    fork
      begin
        logic [63:0] la;
        logic [2:0]  ls;
        int          r8;
        int          gap;
        repeat (25) begin
          gap = $urandom_range(0, 3);
          if (gap != 0) begin
            bus.lsu_req = 1'b0;
            idle(gap);
          end
          la = randAdr();
          r8 = $urandom_range(0, 9);
          ls = (r8 < 8) ? 3'(r8 % 4) : 3'($urandom_range(4, 7));
          if (ls < 3'd4 && $urandom_range(0, 3) != 0) la = la & ~((64'd1 << ls) - 64'd1);
          doTxn(1'b0, la, 1'(($urandom)), ls, {$urandom, $urandom}, 1'b0);
        end
        bus.lsu_req = 1'b0;
      end
      begin
        int gap;
        repeat (25) begin
          gap = $urandom_range(0, 3);
          if (gap != 0) begin
            bus.dbg_req = 1'b0;
            idle(gap);
          end
          doTxn(1'b1, randAdr(), 1'(($urandom)), 3'b000, {$urandom, $urandom}, 1'b0);
        end
        bus.dbg_req = 1'b0;
      end
    join
    idle(5);

    checkOutput("lsu_exp_left", lsu_exp.size(), 0);
    checkOutput("dbg_exp_left", dbg_exp.size(), 0);
    checkOutput("bus_txn_left", bus_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pu_riscv_dmem_arbiter.md
PU_RISCV_DMEM_ARBITER -- requirements
Module: pu_riscv_dmem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the data and address width (32 or 64).
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum number of bus wait cycles before a transaction is forced to error.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have LSU ports: lsu_req in 1, lsu_adr in XLEN, lsu_we in 1, lsu_size in 3 (000 byte, 001 half, 010 word, 011 dword), lsu_d in XLEN.
REQ-006 SHALL have LSU response ports: lsu_ack out 1, lsu_q out XLEN, lsu_misaligned out 1, lsu_err out 1, stall out 1.
REQ-007 SHALL have debug ports: dbg_req in 1, dbg_adr in XLEN, dbg_we in 1, dbg_d in XLEN, dbg_ack out 1, dbg_q out XLEN, dbg_err out 1; debug accesses are always XLEN/8 bytes wide.
REQ-008 SHALL have bus ports: mem_req out 1, mem_adr out XLEN, mem_we out 1, mem_size out 3, mem_d out XLEN, mem_ack in 1, mem_err in 1, mem_q in XLEN.

Function
REQ-009 SHALL implement FSM states IDLE, LSU and DBG, plus a 1-bit last_grant register (LSU/DBG).
REQ-010 In IDLE, requester eligibility SHALL be: X_req=1 and X_ack=0 in the same cycle (no re-grant of a request being acknowledged).
REQ-011 In IDLE, if exactly one requester is eligible, it SHALL be granted; if both are eligible, the one not equal to last_grant SHALL be granted (round-robin).
REQ-012 On an LSU grant, if lsu_size is 1xx, or 011 with XLEN=32, or lsu_adr is not aligned to 2^lsu_size bytes, the FSM SHALL stay in IDLE and next cycle pulse lsu_ack=1 and lsu_misaligned=1 with lsu_err=0 and lsu_q=0; no bus access is made and last_grant is not updated.
REQ-013 On a valid grant, the FSM SHALL latch address, we, size and data, move to LSU or DBG, and update last_grant.
REQ-014 In LSU/DBG, mem_req SHALL be 1 and mem_adr/mem_we/mem_size/mem_d SHALL hold the latched values, stable until termination.
REQ-015 Termination SHALL occur on a cycle with mem_ack=1, mem_err=1, or wait counter = TIMEOUT; the FSM then returns to IDLE at the next edge.
REQ-016 At that edge, the granted requester's ack SHALL go to 1 for exactly one cycle, q SHALL equal mem_q sampled at termination (0 on timeout), and err SHALL equal mem_err OR timeout.
REQ-017 If mem_ack and mem_err are both 1, error SHALL take precedence (err=1).
REQ-018 The wait counter SHALL clear on entry to LSU/DBG, increment each non-terminating cycle, and saturate, never wrapping.
REQ-019 Latency SHALL be: req sampled in IDLE at cycle N, mem_req=1 in N+1; mem_ack in cycle M (M>=N+1) gives ack=1 in M+1. There is a minimum of one IDLE cycle between bus transactions.
REQ-020 stall SHALL be combinational lsu_req AND NOT lsu_ack.
REQ-021 Requesters SHALL hold req and request fields stable until ack; a request dropped before ack while in progress SHALL still complete on the bus, with its ack ignored.

Reset
REQ-022 rstn=0 SHALL asynchronously force state=IDLE, last_grant=DBG, counter=0, and all outputs to 0 (mem_req, acks, errs, lsu_misaligned, q, mem_* buses).
REQ-023 Reset during LSU/DBG SHALL abort the transaction without ack; after release, pending requests SHALL re-arbitrate with LSU winning a tie.

Verification
REQ-024 LSU word load at 0x1000 with mem_ack 3 cycles after mem_req and mem_q=0xDEADBEEF -> exactly one lsu_ack pulse, lsu_q=0xDEADBEEF, lsu_err=0, stall high until the ack cycle.
REQ-025 lsu_req and dbg_req both asserted from reset release, each held until ack and re-asserted immediately -> grants alternate LSU, DBG, LSU, DBG, never the same requester twice in a row while both are pending.
REQ-026 LSU half access at 0x1001, and size=100 -> lsu_misaligned=1 with lsu_ack one cycle later and mem_req never asserted.
REQ-027 mem_ack withheld and TIMEOUT=15 -> mem_req drops after 16 cycles, dbg_ack=1, dbg_err=1, dbg_q=0; mem_ack and mem_err asserted together -> err=1.
REQ-028 rstn pulsed low mid-LSU transaction -> mem_req=0 immediately, no lsu_ack, and the transaction restarts after release with the LSU address intact.
